// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch queue sitting between program memory and dispatch.
// Whole 128-bit lines (four 32-bit instructions) are fetched from memory into a
// line-granular circular buffer. The buffer hands one instruction per cycle,
// together with its PC, to dispatch. A taken jump/branch from dispatch flushes
// every queued line and restarts fetch at the line that holds the target.
//
// Optional feature macro: IFQ_ABORT_EN
//   defined   : abort mirrors jump_branch_valid combinationally, so memory can
//               drop the request that is in flight during a redirect.
//   undefined : abort is tied low. Data returned in a redirect cycle is still
//               discarded by the queue itself.
//
// Parameters
//   DEPTH     queue capacity in lines (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk                in   clock, all state on the rising edge
//   rst                in   asynchronous active-low reset
//   d_valid            in   mem_data carries the line for the current request
//   mem_data[127:0]    in   fetched line, word k at mem_addr + 4k
//   abort              out  cancel the in-flight memory request
//   m_rd_en            out  memory read request
//   mem_addr[31:0]     out  line-aligned fetch address
//   jump_branch_valid  in   redirect request from dispatch
//   jump_branch_add    in   redirect target (word aligned)
//   d_rd_en            in   dispatch pops the head instruction
//   empty              out  no instruction available
//   i_code[31:0]       out  head instruction (0 when empty)
//   pc_out[31:0]       out  PC of i_code (0 when empty)
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         d_valid,
   input  logic [127:0] mem_data,
   output logic         abort,
   output logic         m_rd_en,
   output logic [31:0]  mem_addr,
   input  logic         jump_branch_valid,
   input  logic [31:0]  jump_branch_add,
   input  logic         d_rd_en,
   output logic         empty,
   output logic [31:0]  i_code,
   output logic [31:0]  pc_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Line addresses are always 16-byte aligned, so only bits [31:4] are kept.
   logic [27:0]      fetch_line_q, fetch_line_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       offset_q, offset_d;

   logic [127:0]     line_data_q [DEPTH];
   logic [27:0]      line_addr_q [DEPTH];

   logic             fill;
   logic             pop;
   logic             free_line;
   logic [127:0]     head_data;
   logic [27:0]      head_line;
   logic [31:0]      head_word;

   // The two low bits of the target are always zero and carry no information.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^jump_branch_add[1:0];

   // -------------------------------------------------------------------------
   // Request side
   // -------------------------------------------------------------------------
   assign empty    = (count_q == '0);
   assign m_rd_en  = (count_q < FULL_CNT) && !jump_branch_valid;
   assign mem_addr = {fetch_line_q, 4'b0000};

   // m_rd_en already excludes redirect cycles, so a fill never races a flush.
   assign fill      = m_rd_en && d_valid;
   assign pop       = d_rd_en && !empty && !jump_branch_valid;
   assign free_line = pop && (offset_q == 2'd3);

`ifdef IFQ_ABORT_EN
   assign abort = jump_branch_valid;
`else
   assign abort = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Head presentation
   // -------------------------------------------------------------------------
   assign head_data = line_data_q[rd_ptr_q];
   assign head_line = line_addr_q[rd_ptr_q];
   assign head_word = head_data[{offset_q, 5'b00000} +: 32];

   // Entry storage is not reset, so the head is masked whenever it is invalid.
   assign i_code = empty ? 32'h0 : head_word;
   assign pc_out = empty ? 32'h0 : {head_line, offset_q, 2'b00};

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      fetch_line_d = fetch_line_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      offset_d     = offset_q;

      if (jump_branch_valid) begin
         // Flush: drop every queued line and restart at the target's line.
         // The word offset of the target applies to the first line only,
         // because every later line is entered at offset 0 after a free.
         count_d      = '0;
         rd_ptr_d     = wr_ptr_q;
         fetch_line_d = jump_branch_add[31:4];
         offset_d     = jump_branch_add[3:2];
      end else begin
         if (fill) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            fetch_line_d = fetch_line_q + 28'd1;
         end

         if (pop) begin
            offset_d = offset_q + 2'd1;
            if (free_line) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
         end

         case ({fill, free_line})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Control state
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_line_q <= RESET_PC[31:4];
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         offset_q     <= '0;
      end else begin
         fetch_line_q <= fetch_line_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         offset_q     <= offset_d;
      end
   end

   // -------------------------------------------------------------------------
   // Line storage (validity is tracked by count_q, so no reset is needed)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (fill) begin
         line_data_q[wr_ptr_q] <= mem_data;
         line_addr_q[wr_ptr_q] <= fetch_line_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         d_valid = 1'b0;
   logic [127:0] mem_data = '0;
   logic         abort;
   logic         m_rd_en;
   logic [31:0]  mem_addr;
   logic         jump_branch_valid = 1'b0;
   logic [31:0]  jump_branch_add = '0;
   logic         d_rd_en = 1'b0;
   logic         empty;
   logic [31:0]  i_code;
   logic [31:0]  pc_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .d_valid(d_valid), .mem_data(mem_data),
      .abort(abort), .m_rd_en(m_rd_en), .mem_addr(mem_addr),
      .jump_branch_valid(jump_branch_valid), .jump_branch_add(jump_branch_add),
      .d_rd_en(d_rd_en), .empty(empty), .i_code(i_code), .pc_out(pc_out)
   );

   // ---------------- reference model: a queue of whole lines ----------------
   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
   } line_t;

   line_t       mq[$];
   logic [31:0] m_fpc;
   int          m_off;

   logic        exp_empty, exp_m_rd_en, exp_abort;
   logic [31:0] exp_mem_addr, exp_icode, exp_pc;

   function automatic logic [127:0] seq_line(input logic [31:0] a);
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fpc = RESET_PC;
      m_off = 0;
   endtask

   task automatic calc_exp();
      logic [127:0] tmp;
      exp_empty    = (mq.size() == 0);
      exp_m_rd_en  = (mq.size() < DEPTH) && !jump_branch_valid;
      exp_mem_addr = m_fpc;
`ifdef IFQ_ABORT_EN
      exp_abort = jump_branch_valid;
`else
      exp_abort = 1'b0;
`endif
      if (exp_empty) begin
         exp_icode = 32'h0;
         exp_pc    = 32'h0;
      end else begin
         tmp       = mq[0].data;
         exp_icode = tmp[32*m_off +: 32];
         exp_pc    = mq[0].addr + 32'(4 * m_off);
      end
   endtask

   task automatic model_update();
      bit    do_fill, do_pop;
      line_t ln;
      if (jump_branch_valid) begin
         mq.delete();
         m_fpc = {jump_branch_add[31:4], 4'b0000};
         m_off = int'(jump_branch_add[3:2]);
      end else begin
         do_fill = (mq.size() < DEPTH) && d_valid;
         do_pop  = d_rd_en && (mq.size() > 0);
         if (do_pop) begin
            m_off++;
            if (m_off == 4) begin
               m_off = 0;
               void'(mq.pop_front());
            end
         end
         if (do_fill) begin
            ln.addr = m_fpc;
            ln.data = mem_data;
            mq.push_back(ln);
            m_fpc += 32'd16;
         end
      end
   endtask

   // Apply inputs shortly after a rising edge, settle to the falling edge.
   task automatic drive(input logic dv, input logic rd, input logic jv,
                        input logic [31:0] ja, input logic [127:0] md);
      d_valid           = dv;
      d_rd_en           = rd;
      jump_branch_valid = jv;
      jump_branch_add   = ja;
      mem_data          = md;
      @(negedge clk);
      calc_exp();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic apply_reset();
      d_valid = 0; d_rd_en = 0; jump_branch_valid = 0; jump_branch_add = '0; mem_data = '0;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------- tests -----------------------------------
   task automatic test_reset();
      #1 rst = 1'b0;
      model_reset();
      #2;
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
      n_checks++; if (mem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, RESET_PC); end
      n_checks++; if (i_code !== 32'h0) begin n_errors++; $display("FAIL reset_i_code: got %h want 0", i_code); end
      n_checks++; if (pc_out !== 32'h0) begin n_errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
      n_checks++; if (abort !== 1'b0) begin n_errors++; $display("FAIL reset_abort: got %0b want 0", abort); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      drive(0, 0, 0, 0, '0);
      n_checks++; if (m_rd_en !== 1'b1) begin n_errors++; $display("FAIL reset_m_rd_en: got %0b want 1", m_rd_en); end
      tick();
      // fill two lines, then reset in the middle of a third fill
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      d_valid = 1'b1; mem_data = seq_line(m_fpc);
      #1 rst = 1'b0;
      #1;
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL midreset_empty: got %0b want 1", empty); end
      n_checks++; if (mem_addr !== RESET_PC) begin n_errors++; $display("FAIL midreset_mem_addr: got %h want %h", mem_addr, RESET_PC); end
      model_reset();
      d_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      drive(0, 0, 0, 0, '0);
      n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL postreset_empty: got %0b want 0", empty); end
      n_checks++; if (pc_out !== RESET_PC) begin n_errors++; $display("FAIL postreset_pc_out: got %h want %h", pc_out, RESET_PC); end
      tick();
   endtask

   task automatic test_stream();
      logic [31:0] want;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 0, 0, seq_line(m_fpc));
         if (i >= 1) begin
            want = RESET_PC + 32'(4 * (i - 1));
            n_checks++; if (pc_out !== want) begin n_errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, pc_out, want); end
            n_checks++; if (i_code !== want) begin n_errors++; $display("FAIL stream_icode[%0d]: got %h want %h", i, i_code, want); end
         end
         tick();
      end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      end
      drive(1, 0, 0, 0, {4{32'hDEAD_BEEF}});
      n_checks++; if (m_rd_en !== 1'b0) begin n_errors++; $display("FAIL full_m_rd_en: got %0b want 0", m_rd_en); end
      n_checks++; if (mem_addr !== 32'h0040_0040) begin n_errors++; $display("FAIL full_mem_addr: got %h want 00400040", mem_addr); end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, '0);
         if (i == 3) begin
            n_checks++; if (m_rd_en !== 1'b0) begin n_errors++; $display("FAIL full_last_pop_m_rd_en: got %0b want 0", m_rd_en); end
         end
         tick();
      end
      drive(0, 0, 0, 0, '0);
      n_checks++; if (m_rd_en !== 1'b1) begin n_errors++; $display("FAIL full_freed_m_rd_en: got %0b want 1", m_rd_en); end
      n_checks++; if (pc_out !== 32'h0040_0010) begin n_errors++; $display("FAIL full_freed_pc: got %h want 00400010", pc_out); end
      tick();
   endtask

   task automatic test_redirect();
      apply_reset();
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      drive(1, 1, 0, 0, seq_line(m_fpc)); tick();
      drive(1, 1, 1, 32'h0040_001C, seq_line(m_fpc));
      n_checks++; if (m_rd_en !== 1'b0) begin n_errors++; $display("FAIL redir_m_rd_en: got %0b want 0", m_rd_en); end
      n_checks++; if (abort !== exp_abort) begin n_errors++; $display("FAIL redir_abort: got %0b want %0b", abort, exp_abort); end
      tick();
      drive(0, 0, 0, 0, '0);
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL redir_empty: got %0b want 1", empty); end
      n_checks++; if (mem_addr !== 32'h0040_0010) begin n_errors++; $display("FAIL redir_mem_addr: got %h want 00400010", mem_addr); end
      tick();
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      drive(1, 1, 0, 0, seq_line(m_fpc));
      n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL redir_head_empty: got %0b want 0", empty); end
      n_checks++; if (pc_out !== 32'h0040_001C) begin n_errors++; $display("FAIL redir_head_pc: got %h want 0040001c", pc_out); end
      n_checks++; if (i_code !== 32'h0040_001C) begin n_errors++; $display("FAIL redir_head_icode: got %h want 0040001c", i_code); end
      tick();
      drive(0, 0, 0, 0, '0);
      n_checks++; if (pc_out !== 32'h0040_0020) begin n_errors++; $display("FAIL redir_next_pc: got %h want 00400020", pc_out); end
      n_checks++; if (i_code !== 32'h0040_0020) begin n_errors++; $display("FAIL redir_next_icode: got %h want 00400020", i_code); end
      tick();
   endtask

   task automatic test_pop_empty();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, '0);
         n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL popempty_empty[%0d]: got %0b want 1", i, empty); end
         tick();
      end
      drive(1, 0, 0, 0, seq_line(m_fpc)); tick();
      drive(0, 0, 0, 0, '0);
      n_checks++; if (pc_out !== RESET_PC) begin n_errors++; $display("FAIL popempty_pc: got %h want %h", pc_out, RESET_PC); end
      n_checks++; if (i_code !== RESET_PC) begin n_errors++; $display("FAIL popempty_icode: got %h want %h", i_code, RESET_PC); end
      tick();
   endtask

   task automatic test_abort();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, i[0], 32'h0040_0100 + 32'(i * 4), seq_line(m_fpc));
         n_checks++; if (abort !== exp_abort) begin n_errors++; $display("FAIL abort[%0d]: got %0b want %0b", i, abort, exp_abort); end
         tick();
      end
   endtask

   task automatic test_random();
      logic jv;
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         jv = ($urandom_range(0, 15) == 0);
         drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), jv,
               $urandom & 32'hFFFF_FFFC, {$urandom, $urandom, $urandom, $urandom});
         n_checks++; if (empty !== exp_empty) begin n_errors++; $display("FAIL rnd_empty[%0d]: got %0b want %0b", i, empty, exp_empty); end
         n_checks++; if (m_rd_en !== exp_m_rd_en) begin n_errors++; $display("FAIL rnd_m_rd_en[%0d]: got %0b want %0b", i, m_rd_en, exp_m_rd_en); end
         n_checks++; if (mem_addr !== exp_mem_addr) begin n_errors++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, exp_mem_addr); end
         n_checks++; if (i_code !== exp_icode) begin n_errors++; $display("FAIL rnd_icode[%0d]: got %h want %h", i, i_code, exp_icode); end
         n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
         n_checks++; if (abort !== exp_abort) begin n_errors++; $display("FAIL rnd_abort[%0d]: got %0b want %0b", i, abort, exp_abort); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect();
      test_pop_empty();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch queue between program memory and dispatch. It fetches 128-bit lines of four 32-bit instructions from program memory into a line-granular circular buffer. It presents one instruction, with its PC, per cycle to dispatch. Taken jumps and branches from dispatch flush the queue and redirect fetch.

## Interface
Parameters:
- DEPTH, 4: queue capacity in 128-bit lines (power of 2, ≥2).
- RESET_PC, 32'h0040_0000: first fetch address after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- d_valid  in  1  mem_data valid for the current request.
- mem_data  in  128  fetched line; word k = bits [32k+31:32k] at address mem_addr+4k.
- abort  out  1  cancel any in-flight memory request.
- m_rd_en  out  1  memory read request.
- mem_addr  out  32  line-aligned fetch address, bits [3:0]=0.
- jump_branch_valid  in  1  redirect request from dispatch.
- jump_branch_add  in  32  redirect target, word aligned.
- d_rd_en  in  1  dispatch pops head instruction.
- empty  out  1  no instruction available.
- i_code  out  32  head instruction.
- pc_out  out  32  PC of i_code.

## Operation
- State:
  - fetch_pc, line aligned.
  - DEPTH entries of {line data, line address}.
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - line count, 0..DEPTH.
  - head word offset, 2 bits.
- m_rd_en = (count < DEPTH) && !jump_branch_valid.
- mem_addr = fetch_pc.
- Fill: at an edge with m_rd_en && d_valid:
  - mem_data and fetch_pc are stored at wr_ptr.
  - wr_ptr++ and fetch_pc += 16 (wraps at 2^32).
- empty = (count == 0).
- i_code = word[offset] of the entry at rd_ptr.
- pc_out = entry address + 4*offset.
- When empty, i_code and pc_out drive 0.
- Pop: at an edge with d_rd_en && !empty:
  - offset++.
  - If offset was 3, the line is freed: rd_ptr++ and offset wraps to 0.
  - d_rd_en while empty is ignored.
- Fill and free in the same cycle: count unchanged.
- Redirect: at an edge with jump_branch_valid:
  - All entries are invalidated; count=0 and rd_ptr=wr_ptr.
  - fetch_pc ← {jump_branch_add[31:4],4'b0}.
  - offset ← jump_branch_add[3:2].
  - Fill and pop in that cycle are discarded.
  - Redirect has priority over everything.
- Only the first line after a redirect starts at a non-zero offset.
- abort: see Configuration.

## Timing
- Reset (asynchronous, rst=0):
  - fetch_pc=RESET_PC, count=0, pointers=0, offset=0.
  - Outputs: empty=1, m_rd_en=1 (after rst release), mem_addr=RESET_PC, i_code=0, pc_out=0, abort=0.
- Reset mid-operation discards all queued lines.
- Fill latency: a line accepted at edge N is visible on i_code/pc_out with empty=0 during cycle N+1.
- Throughput: one line accepted and one instruction popped per cycle.
- Full (count==DEPTH): m_rd_en=0 combinationally and mem_data is ignored.
- Full with a freeing pop at edge N: m_rd_en=1 in cycle N+1.
- Redirect at edge N:
  - m_rd_en=0 during cycle N.
  - empty=1 and mem_addr = target line during cycle N+1.
  - With d_valid, the target line is written at edge N+1; the first valid head appears in cycle N+2.

## Configuration
- IFQ_ABORT_EN defined:
  - abort = jump_branch_valid, combinational.
  - Memory must drop the current request.
- IFQ_ABORT_EN undefined:
  - abort tied to 0.
  - Queue behaviour is otherwise identical; data returned during a redirect cycle is already discarded by the redirect rule.

## Test plan
- Reset:
  - Assert rst=0 mid-fill → immediately empty=1, mem_addr=0x0040_0000.
  - After rst=1, one d_valid line → empty=0, pc_out=0x0040_0000.
- Sequential stream:
  - d_valid=1 every cycle with mem_data words {3,2,1,0}.
  - Pop every cycle → i_code 0,1,2,3, pc_out 0x00400000..0x0040000C, then the next line at 0x00400010.
- Full:
  - No pops, d_valid=1 → after 4 lines m_rd_en=0 and mem_addr=0x00400040.
  - One line freed by 4 pops → m_rd_en=1 next cycle.
- Unaligned redirect:
  - jump_branch_valid with 0x0040001C while the queue holds data → next cycle empty=1, mem_addr=0x00400010.
  - After fill → pc_out=0x0040001C with i_code=word 3.
  - Next pop → pc_out=0x00400020.
- Pop when empty:
  - d_rd_en=1 with empty=1 → no pointer change.
  - The first later instruction is still the line head.
- Abort:
  - With IFQ_ABORT_EN, abort=1 exactly in jump cycles.
  - Without IFQ_ABORT_EN, abort stays 0 throughout.
